// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage access unit (master) and the data memory (slave).
// One request is held on mreq until a single-cycle mack answers it.
interface mem_access_unit_if;
  logic        mreq;
  logic        mwe;
  logic [31:0] maddr;
  logic [31:0] mwdata;
  logic [3:0]  mwstrb;
  logic [31:0] mrdata;
  logic        mack;

  modport master (
    output mreq, mwe, maddr, mwdata, mwstrb,
    input  mrdata, mack
  );

  modport slave (
    input  mreq, mwe, maddr, mwdata, mwstrb,
    output mrdata, mack
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: aligns stores, extends loads and stalls the pipe during an access.
// Define MEM_MISALIGN_SPLIT_EN to turn misaligned h/w accesses into two word transfers.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [31:0]       dm_addr,
  input  logic [31:0]       dm_data,
  input  logic [3:0]        ctrl_mem,
  input  logic [2:0]        funct3,
  output logic              mem_busy,
  output logic              mem_done,
  output logic [31:0]       dm_rdata,
  output logic              misalign,
  output logic              bus_err,
  mem_access_unit_if.master mbus
);

  typedef enum logic [1:0] {StIdle, StReq, StReq2, StDone} state_e;

  state_e      state_q, state_d;
  logic        dmwe, dmrd, start, is_h, is_w, mis, tmo, req, enter_done;
  logic [3:0]  byte_mask, strb_lo;
  logic [31:0] wdata_rep, wdata_lo, ld_raw, ld_ext;
  logic [63:0] rd_wide;
  logic [1:0]  a_q;
  logic [2:0]  f3_q;
  logic        we_q, mis_q, err_q;
  logic [7:0]  cnt_q;
  logic [31:0] maddr_q, mwdata_q, dm_rdata_q;
  logic [3:0]  mwstrb_q;
  logic        unused_ctrl;

  assign unused_ctrl = ^ctrl_mem[3:2];
  assign dmwe        = ctrl_mem[1];
  assign dmrd        = ctrl_mem[0];
  assign start       = (state_q == StIdle) && (dmwe || dmrd);
  assign is_h        = funct3[1:0] == 2'b01;
  // Every code with funct3[1] set, including the undefined ones, behaves as a word.
  assign is_w        = funct3[1];
  assign mis         = (is_h && dm_addr[0]) || (is_w && (dm_addr[1:0] != 2'b00));
  assign tmo         = cnt_q == 8'(TIMEOUT_CYC - 1);
  assign byte_mask   = is_w ? 4'b1111 : (is_h ? 4'b0011 : 4'b0001);
  assign wdata_rep   = is_w ? dm_data : (is_h ? {2{dm_data[15:0]}} : {4{dm_data[7:0]}});
  assign enter_done  = (state_d == StDone) && (state_q != StDone);

`ifdef MEM_MISALIGN_SPLIT_EN
  logic        split_q;
  logic [31:0] wdata_hi_q, rd_lo_q, st_sized;
  logic [3:0]  strb_hi_q;
  logic [63:0] st_wide;
  logic [7:0]  strb_wide;

  // Lanes of an access straddling a word boundary spill into the upper half of an 8-byte window.
  assign st_sized  = is_w ? dm_data : (is_h ? {16'h0, dm_data[15:0]} : {24'h0, dm_data[7:0]});
  assign st_wide   = {32'h0, st_sized} << {dm_addr[1:0], 3'b000};
  assign strb_wide = {4'h0, byte_mask} << dm_addr[1:0];
  assign strb_lo   = strb_wide[3:0];
  assign wdata_lo  = mis ? st_wide[31:0] : wdata_rep;
  assign rd_wide   = (state_q == StReq2) ? {mbus.mrdata, rd_lo_q} : {32'h0, mbus.mrdata};
`else
  assign strb_lo   = byte_mask << dm_addr[1:0];
  assign wdata_lo  = wdata_rep;
  assign rd_wide   = {32'h0, mbus.mrdata};
`endif

  always_comb begin
    ld_raw = 32'(rd_wide >> {a_q, 3'b000});
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_raw[7]}}, ld_raw[7:0]};
      3'b001:  ld_ext = {{16{ld_raw[15]}}, ld_raw[15:0]};
      3'b100:  ld_ext = {24'h0, ld_raw[7:0]};
      3'b101:  ld_ext = {16'h0, ld_raw[15:0]};
      default: ld_ext = ld_raw;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
`ifdef MEM_MISALIGN_SPLIT_EN
          state_d = StReq;
`else
          state_d = mis ? StDone : StReq;
`endif
        end
      end
      StReq: begin
        if (mbus.mack) begin
`ifdef MEM_MISALIGN_SPLIT_EN
          state_d = split_q ? StReq2 : StDone;
`else
          state_d = StDone;
`endif
        end else if (tmo) begin
          state_d = StDone;
        end
      end
`ifdef MEM_MISALIGN_SPLIT_EN
      StReq2: begin
        if (mbus.mack || tmo) state_d = StDone;
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req         = (state_q == StReq) || (state_q == StReq2);
    mbus.mreq   = req;
    mem_done    = state_q == StDone;
    // Held low during reset so the stalled pipe is released at once.
    mem_busy    = rstn && (start || req);
    misalign    = mem_done && mis_q;
    bus_err     = mem_done && err_q;
    mbus.mwe    = we_q;
    mbus.maddr  = maddr_q;
    mbus.mwdata = mwdata_q;
    mbus.mwstrb = mwstrb_q;
    dm_rdata    = dm_rdata_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_q        <= '0;
      f3_q       <= '0;
      we_q       <= 1'b0;
      maddr_q    <= '0;
      mwdata_q   <= '0;
      mwstrb_q   <= '0;
      cnt_q      <= '0;
      dm_rdata_q <= '0;
      mis_q      <= 1'b0;
      err_q      <= 1'b0;
`ifdef MEM_MISALIGN_SPLIT_EN
      split_q    <= 1'b0;
      wdata_hi_q <= '0;
      strb_hi_q  <= '0;
      rd_lo_q    <= '0;
`endif
    end else begin
      if (start && (state_d == StReq)) begin
        a_q      <= dm_addr[1:0];
        f3_q     <= funct3;
        we_q     <= dmwe;
        maddr_q  <= {dm_addr[31:2], 2'b00};
        mwdata_q <= dmwe ? wdata_lo : '0;
        mwstrb_q <= dmwe ? strb_lo : '0;
`ifdef MEM_MISALIGN_SPLIT_EN
        split_q    <= mis;
        wdata_hi_q <= dmwe ? st_wide[63:32] : '0;
        strb_hi_q  <= dmwe ? strb_wide[7:4] : '0;
`endif
      end
`ifdef MEM_MISALIGN_SPLIT_EN
      // Second word of a split access; the address wraps naturally at the top of memory.
      if ((state_q == StReq) && mbus.mack && split_q) begin
        maddr_q  <= maddr_q + 32'd4;
        mwdata_q <= wdata_hi_q;
        mwstrb_q <= strb_hi_q;
        rd_lo_q  <= mbus.mrdata;
      end
`endif
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (req) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (enter_done) begin
        dm_rdata_q <= (!we_q && mbus.mack && (state_q != StIdle)) ? ld_ext : '0;
        mis_q      <= state_q == StIdle;
        err_q      <= (state_q != StIdle) && !mbus.mack;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed spec cases plus random loads/stores against a byte-level
// memory model; a behavioural memory answers requests after a programmable latency.
module tb_mem_access_unit;
  localparam int unsigned TMO = 4;
`ifdef MEM_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] dm_addr, dm_data, dm_rdata;
  logic [3:0]  ctrl_mem;
  logic [2:0]  funct3;
  logic        mem_busy, mem_done, misalign, bus_err;

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT_CYC(TMO)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .dm_addr  (dm_addr),
    .dm_data  (dm_data),
    .ctrl_mem (ctrl_mem),
    .funct3   (funct3),
    .mem_busy (mem_busy),
    .mem_done (mem_done),
    .dm_rdata (dm_rdata),
    .misalign (misalign),
    .bus_err  (bus_err),
    .mbus     (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  bit [31:0] mem_w [bit [31:0]];  // memory seen by the DUT
  bit [7:0]  ref_b [bit [31:0]];  // expected byte image
  int        lat_cfg = 1;
  int        rcnt = 0;
  int        mreq_cycles = 0;
  bit [31:0] rq_addr[$], rq_wdata[$];
  bit [3:0]  rq_strb[$];
  bit        rq_we[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory responder: mack in the lat_cfg-th cycle of each request, never when lat_cfg is 0.
  initial begin
    bus.mack   = 1'b0;
    bus.mrdata = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        bus.mack = 1'b0;
        rcnt     = 0;
      end else begin
        if (bus.mack) begin
          bus.mack = 1'b0;
          rcnt     = 0;
        end
        if (bus.mreq) begin
          mreq_cycles++;
          rcnt++;
          if (rcnt == 1) begin
            rq_addr.push_back(bus.maddr);
            rq_we.push_back(bus.mwe);
            rq_strb.push_back(bus.mwstrb);
            rq_wdata.push_back(bus.mwdata);
          end
          if (lat_cfg != 0 && rcnt == lat_cfg) begin
            bit [31:0] w;
            w = mem_w[bus.maddr];
            bus.mrdata = w;
            bus.mack   = 1'b1;
            if (bus.mwe) begin
              for (int i = 0; i < 4; i++) if (bus.mwstrb[i]) w[8*i +: 8] = bus.mwdata[8*i +: 8];
              mem_w[bus.maddr] = w;
            end
          end
        end else begin
          rcnt = 0;
        end
      end
    end
  end

  function automatic void set_word(input bit [31:0] a, input bit [31:0] w);
    mem_w[a] = w;
    for (int k = 0; k < 4; k++) ref_b[a + 32'(k)] = w[8*k +: 8];
  endfunction

  function automatic bit [31:0] ref_word(input bit [31:0] a);
    bit [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = ref_b[a + 32'(k)];
    return w;
  endfunction

  function automatic int nbytes(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
  endfunction

  function automatic bit [31:0] ref_load(input bit [31:0] a, input logic [2:0] f3);
    int n;
    bit [31:0] v;
    n = nbytes(f3);
    v = '0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = ref_b[a + 32'(k)];
    if (n == 1) return f3[2] ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]};
    if (n == 2) return f3[2] ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic do_access(input string tag, input logic [3:0] ctrl, input logic [2:0] f3,
                           input bit [31:0] a, input bit [31:0] d, input int lat);
    int        n, busy, exp_nreq, exp_busy, exp_mcyc, mreq0;
    bit        we, is_mis, tout, done_seen;
    bit [31:0] exp_rd, w0, rep;
    bit [7:0]  strb8;
    we     = ctrl[1];
    n      = nbytes(f3);
    is_mis = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
    tout   = (lat == 0) && !(is_mis && !SPLIT);
    exp_nreq = tout ? 1 : (is_mis ? (SPLIT ? 2 : 0) : 1);
    exp_busy = tout ? 1 + int'(TMO) : 1 + exp_nreq * lat;
    exp_mcyc = tout ? int'(TMO) : exp_nreq * lat;
    exp_rd   = (we || tout || (is_mis && !SPLIT)) ? 32'h0 : ref_load(a, f3);
    if (we && !tout && !(is_mis && !SPLIT))
      for (int k = 0; k < n; k++) ref_b[a + 32'(k)] = d[8*k +: 8];
    strb8 = 8'((n == 1) ? 4'b0001 : ((n == 2) ? 4'b0011 : 4'b1111)) << a[1:0];
    rep   = (n == 1) ? {4{d[7:0]}} : ((n == 2) ? {2{d[15:0]}} : d);
    w0    = {a[31:2], 2'b00};
    rq_addr.delete(); rq_we.delete(); rq_strb.delete(); rq_wdata.delete();
    lat_cfg = lat;
    mreq0   = mreq_cycles;

    @(negedge clk);
    dm_addr = a; dm_data = d; funct3 = f3; ctrl_mem = ctrl;
    busy = 0;
    done_seen = 1'b0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      #1;
      if (mem_done) begin
        done_seen = 1'b1;
        break;
      end
      if (mem_busy) busy++;
      @(negedge clk);
    end
    check({tag, ".done"}, 32'(done_seen), 32'd1);
    check({tag, ".busy_cycles"}, busy, exp_busy);
    check({tag, ".busy_at_done"}, 32'(mem_busy), 32'd0);
    check({tag, ".rdata"}, dm_rdata, exp_rd);
    check({tag, ".misalign"}, 32'(misalign), 32'(is_mis && !SPLIT));
    check({tag, ".bus_err"}, 32'(bus_err), 32'(tout));
    check({tag, ".nreq"}, rq_addr.size(), exp_nreq);
    check({tag, ".mreq_cycles"}, mreq_cycles - mreq0, exp_mcyc);
    if (rq_addr.size() > 0) begin
      check({tag, ".maddr0"}, rq_addr[0], w0);
      check({tag, ".mwe0"}, 32'(rq_we[0]), 32'(we));
      check({tag, ".mwstrb0"}, 32'(rq_strb[0]), we ? 32'(strb8[3:0]) : 32'h0);
      if (we && !is_mis) check({tag, ".mwdata0"}, rq_wdata[0], rep);
    end
    if (rq_addr.size() > 1) begin
      check({tag, ".maddr1"}, rq_addr[1], w0 + 32'd4);
      check({tag, ".mwstrb1"}, 32'(rq_strb[1]), we ? 32'(strb8[7:4]) : 32'h0);
    end
    check({tag, ".mem_w0"}, mem_w[w0], ref_word(w0));
    check({tag, ".mem_w1"}, mem_w[w0 + 32'd4], ref_word(w0 + 32'd4));
    ctrl_mem = 4'b0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [31:0] a, d;
    bit [2:0]  f3;
    bit        we;

    rstn = 1'b0; ctrl_mem = '0; dm_addr = '0; dm_data = '0; funct3 = '0;
    for (int i = 0; i < 256; i += 4) set_word(32'h1000 + 32'(i), $urandom);
    repeat (2) @(negedge clk);
    #1;
    check("reset.mreq", 32'(bus.mreq), 32'd0);
    check("reset.mem_busy", 32'(mem_busy), 32'd0);
    check("reset.mem_done", 32'(mem_done), 32'd0);
    check("reset.dm_rdata", dm_rdata, 32'd0);
    check("reset.maddr", bus.maddr, 32'd0);
    check("reset.mwstrb", 32'(bus.mwstrb), 32'd0);
    check("reset.mwe", 32'(bus.mwe), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    set_word(32'h100, 32'hDEADBEEF);
    do_access("lw_lat3", 4'b0001, 3'b010, 32'h100, 32'h0, 3);
    check("lw_lat3.value", dm_rdata, 32'hDEADBEEF);
    repeat (3) @(negedge clk);
    #1;
    check("rdata_hold", dm_rdata, 32'hDEADBEEF);

    set_word(32'h100, 32'h80112233);
    do_access("lb", 4'b0001, 3'b000, 32'h103, 32'h0, 1);
    check("lb.value", dm_rdata, 32'hFFFFFF80);
    do_access("lbu", 4'b0001, 3'b100, 32'h103, 32'h0, 2);
    check("lbu.value", dm_rdata, 32'h00000080);

    set_word(32'h200, 32'h11223344);
    do_access("sh", 4'b0010, 3'b001, 32'h202, 32'h0000ABCD, 1);
    check("sh.maddr", rq_addr[0], 32'h200);
    check("sh.mwstrb", 32'(rq_strb[0]), 32'hC);
    check("sh.mwdata", rq_wdata[0], 32'hABCDABCD);
    check("sh.mwe", 32'(rq_we[0]), 32'd1);

    set_word(32'h100, 32'h44332211);
    set_word(32'h104, 32'h88776655);
    do_access("lw_mis", 4'b0001, 3'b010, 32'h101, 32'h0, 2);
    check("lw_mis.value", dm_rdata, SPLIT ? 32'h55443322 : 32'h0);

    do_access("lw_timeout", 4'b0001, 3'b010, 32'h100, 32'h0, 0);
    do_access("sw_and_rd", 4'b0011, 3'b010, 32'h104, 32'hCAFEF00D, 1);

    set_word(32'hFFFFFFFC, 32'hA1B2C3D4);
    set_word(32'h0, 32'h5E6F7081);
    do_access("lw_wrap", 4'b0001, 3'b010, 32'hFFFFFFFE, 32'h0, 1);
    do_access("lh_wrap", 4'b0001, 3'b001, 32'hFFFFFFFF, 32'h0, 2);
    do_access("sh_wrap", 4'b0010, 3'b001, 32'hFFFFFFFF, 32'h00009AB7, 1);
    do_access("sb_top", 4'b1110, 3'b000, 32'hFFFFFFFD, 32'h000000E5, 1);

    // Reset while a request is outstanding.
    lat_cfg = 0;
    @(negedge clk);
    dm_addr = 32'h100; funct3 = 3'b010; ctrl_mem = 4'b0001;
    @(negedge clk);
    #1;
    check("rst_req.mreq_before", 32'(bus.mreq), 32'd1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rst_req.mreq", 32'(bus.mreq), 32'd0);
    check("rst_req.busy", 32'(mem_busy), 32'd0);
    check("rst_req.rdata", dm_rdata, 32'd0);
    @(negedge clk);
    ctrl_mem = 4'b0000;
    rstn = 1'b1;
    #1;
    check("rst_req.idle_busy", 32'(mem_busy), 32'd0);
    do_access("lw_after_rst", 4'b0001, 3'b010, 32'h104, 32'h0, 2);

    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      a  = 32'h1000 + 32'($urandom_range(0, 247));
      d  = $urandom;
      do_access($sformatf("rnd%0d", i),
                we ? {2'($urandom), 1'b1, 1'($urandom)} : {2'($urandom), 2'b01},
                f3, a, d, $urandom_range(1, 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
